// File: rtl/zz_arbiter_if.sv
// Handshake bundle between zz_arbiter, its luma/chroma requesters and the zigzag engine.
// The slave modport is the arbiter's view; master is the surrounding system.
interface zz_arbiter_if;
  logic          enable;
  logic          req0_valid;
  logic [1023:0] req0_block;
  logic          req0_ready;
  logic          req1_valid;
  logic [1023:0] req1_block;
  logic          req1_ready;
  logic          zz_start;
  logic [1023:0] zz_block;
  logic          zz_block_valid;
  logic          zz_block_ready;
  logic          zz_done;
  logic          out_valid;
  logic          out_tag;
  logic [15:0]   blocks_done;
  logic          timeout_err;

  modport slave (
    input  enable, req0_valid, req0_block, req1_valid, req1_block,
           zz_block_ready, zz_done,
    output req0_ready, req1_ready, zz_start, zz_block, zz_block_valid,
           out_valid, out_tag, blocks_done, timeout_err
  );

  modport master (
    output enable, req0_valid, req0_block, req1_valid, req1_block,
           zz_block_ready, zz_done,
    input  req0_ready, req1_ready, zz_start, zz_block, zz_block_valid,
           out_valid, out_tag, blocks_done, timeout_err
  );
endinterface

// File: rtl/zz_arbiter.sv
// zz_arbiter: round-robin arbiter feeding luma/chroma blocks to one zigzag engine, with
// completion tagging, a wrapping completed-block counter and a sticky engine-timeout flag.
module zz_arbiter #(
  parameter int TIMEOUT = 200
) (
  input  logic        clk,
  input  logic        rst,
  zz_arbiter_if.slave bus
);

  localparam int TW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

  state_t         state_r;
  state_t         state_nxt_s;
  logic           grant_r;
  logic           grant_nxt_s;
  logic           last_grant_r;
  logic           last_grant_nxt_s;
  logic [TW-1:0]  timer_r;
  logic [TW-1:0]  timer_nxt_s;
  logic [1023:0]  zz_block_r;
  logic [1023:0]  zz_block_nxt_s;
  logic           zz_start_r;
  logic           zz_start_nxt_s;
  logic           zz_block_valid_r;
  logic           out_valid_r;
  logic           out_valid_nxt_s;
  logic           out_tag_r;
  logic           out_tag_nxt_s;
  logic [15:0]    blocks_done_r;
  logic [15:0]    blocks_done_nxt_s;
  logic           timeout_err_r;
  logic           timeout_err_nxt_s;

  logic           any_valid_s;
  logic           grant_next_s;
  logic           accept_s;
  logic           ready0_s;
  logic           ready1_s;
  logic           xfer0_s;
  logic           xfer1_s;

  // Round-robin pick: a lone requester wins, a tie goes to whoever was not served last.
  always_comb begin
    any_valid_s = bus.req0_valid | bus.req1_valid;
    if (bus.req0_valid && bus.req1_valid) begin
      grant_next_s = ~last_grant_r;
    end else if (bus.req1_valid) begin
      grant_next_s = 1'b1;
    end else begin
      grant_next_s = 1'b0;
    end
    accept_s = (state_r == IDLE) && bus.enable && bus.zz_block_ready && !rst && any_valid_s;
    ready0_s = accept_s && (grant_next_s == 1'b0);
    ready1_s = accept_s && (grant_next_s == 1'b1);
    xfer0_s  = ready0_s && bus.req0_valid;
    xfer1_s  = ready1_s && bus.req1_valid;
  end

  // Next-state and next-output logic for the issue/wait controller.
  always_comb begin
    state_nxt_s       = state_r;
    grant_nxt_s       = grant_r;
    last_grant_nxt_s  = last_grant_r;
    timer_nxt_s       = timer_r;
    zz_block_nxt_s    = zz_block_r;
    zz_start_nxt_s    = 1'b0;
    out_valid_nxt_s   = 1'b0;
    out_tag_nxt_s     = out_tag_r;
    blocks_done_nxt_s = blocks_done_r;
    timeout_err_nxt_s = timeout_err_r;
    case (state_r)
      IDLE: begin
        if (xfer0_s || xfer1_s) begin
          state_nxt_s    = ISSUE;
          grant_nxt_s    = xfer1_s;
          zz_block_nxt_s = xfer1_s ? bus.req1_block : bus.req0_block;
          zz_start_nxt_s = 1'b1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ISSUE: begin
        state_nxt_s = WAIT_DONE;
        timer_nxt_s = {TW{1'b0}};
      end
      WAIT_DONE: begin
        // A done arriving on the expiry cycle still counts as a normal completion.
        if (bus.zz_done) begin
          out_valid_nxt_s   = 1'b1;
          out_tag_nxt_s     = grant_r;
          blocks_done_nxt_s = blocks_done_r + 16'd1;
          last_grant_nxt_s  = grant_r;
          state_nxt_s       = IDLE;
        end else if (timer_r == TIMER_LAST) begin
          timer_nxt_s       = timer_r + {{(TW-1){1'b0}}, 1'b1};
          timeout_err_nxt_s = 1'b1;
          last_grant_nxt_s  = grant_r;
          state_nxt_s       = IDLE;
        end else begin
          timer_nxt_s = timer_r + {{(TW-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Controller state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Datapath and registered outputs; last_grant resets to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_r          <= 1'b0;
      last_grant_r     <= 1'b1;
      timer_r          <= {TW{1'b0}};
      zz_block_r       <= {1024{1'b0}};
      zz_start_r       <= 1'b0;
      zz_block_valid_r <= 1'b0;
      out_valid_r      <= 1'b0;
      out_tag_r        <= 1'b0;
      blocks_done_r    <= 16'd0;
      timeout_err_r    <= 1'b0;
    end else begin
      grant_r          <= grant_nxt_s;
      last_grant_r     <= last_grant_nxt_s;
      timer_r          <= timer_nxt_s;
      zz_block_r       <= zz_block_nxt_s;
      zz_start_r       <= zz_start_nxt_s;
      zz_block_valid_r <= zz_start_nxt_s;
      out_valid_r      <= out_valid_nxt_s;
      out_tag_r        <= out_tag_nxt_s;
      blocks_done_r    <= blocks_done_nxt_s;
      timeout_err_r    <= timeout_err_nxt_s;
    end
  end

  assign bus.req0_ready     = ready0_s;
  assign bus.req1_ready     = ready1_s;
  assign bus.zz_start       = zz_start_r;
  assign bus.zz_block       = zz_block_r;
  assign bus.zz_block_valid = zz_block_valid_r;
  assign bus.out_valid      = out_valid_r;
  assign bus.out_tag        = out_tag_r;
  assign bus.blocks_done    = blocks_done_r;
  assign bus.timeout_err    = timeout_err_r;

endmodule

// File: tb/tb_zz_arbiter.sv
// Directed scoreboard bench for zz_arbiter: single request, ties, streaming, hung engine
// and reset in the middle of a transfer.
module tb_zz_arbiter;
  localparam int TO = 200;

  typedef struct packed {
    logic          tag;
    logic [1023:0] blk;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          eng_done;
  logic          man_done;
  logic          eng_hang;
  int            eng_lat;
  int            eng_cnt;
  int            cyc = 0;
  int            total = 0;
  int            bad = 0;
  int            done_cnt;
  int            start_cyc;
  int            exp_start_cyc;
  int            terr_cyc;
  logic          terr_prev;
  int            k;
  logic [1023:0] blk0;
  logic [1023:0] blk1;
  exp_t          sb[$];
  bit            grants[$];
  bit            tags[$];
  int            xfer_cyc[$];
  bit            tie_seq[4] = '{1'b0, 1'b1, 1'b0, 1'b1};

  zz_arbiter_if bus();

  zz_arbiter #(.TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  assign bus.zz_done = eng_done | man_done;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_blk(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got low64 %0h want low64 %0h", tag, obs[63:0], exp[63:0]);
    end
  endtask

  function automatic logic [1023:0] rand_blk();
    logic [1023:0] r;
    for (int i = 0; i < 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_grants(input int n, input int budget, input string tag);
    int c = 0;
    while (grants.size() < n && c < budget) begin
      @(posedge clk);
      c++;
    end
    #1;
    chk(tag, 64'(grants.size() >= n), 64'd1);
  endtask

  task automatic wait_done(input int n, input int budget, input string tag);
    int c = 0;
    while (done_cnt < n && c < budget) begin
      @(posedge clk);
      c++;
    end
    #1;
    chk(tag, 64'(done_cnt >= n), 64'd1);
  endtask

  // Engine model: answers zz_start with a one-cycle done eng_lat cycles later unless hung.
  always @(negedge clk) begin
    if (rst) begin
      eng_cnt  <= 0;
      eng_done <= 1'b0;
    end else if (bus.zz_start) begin
      eng_cnt  <= eng_lat;
      eng_done <= 1'b0;
    end else if (eng_cnt > 0) begin
      eng_cnt  <= eng_cnt - 1;
      eng_done <= (eng_cnt == 1) && !eng_hang;
    end else begin
      eng_done <= 1'b0;
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: push on every transfer, check the start and the completion against it.
  always @(negedge clk) begin
    terr_prev <= bus.timeout_err;
    if (bus.timeout_err === 1'b1 && terr_prev !== 1'b1) terr_cyc <= cyc;
    if (rst) begin
      sb.delete();
      done_cnt <= 0;
    end else begin
      if ((bus.req0_valid && bus.req0_ready) || (bus.req1_valid && bus.req1_ready)) begin
        chk("ready_onehot", 64'(bus.req0_ready & bus.req1_ready), 64'd0);
        sb.push_back({bus.req1_ready, bus.req1_ready ? bus.req1_block : bus.req0_block});
        grants.push_back(bus.req1_ready);
        xfer_cyc.push_back(cyc);
        exp_start_cyc <= cyc + 1;
      end
      if (bus.zz_start || bus.zz_block_valid) begin
        start_cyc <= cyc;
        chk("start_vs_bvalid", 64'(bus.zz_start), 64'(bus.zz_block_valid));
        chk("start_latency", 64'(cyc), 64'(exp_start_cyc));
        chk("start_pending", 64'(sb.size() == 0), 64'd0);
        if (sb.size() != 0) chk_blk("start_block", bus.zz_block, sb[0].blk);
      end
      if (bus.out_valid) begin
        chk("out_pending", 64'(sb.size() == 0), 64'd0);
        if (sb.size() != 0) begin
          chk("out_tag", 64'(bus.out_tag), 64'(sb[0].tag));
          chk_blk("held_block", bus.zz_block, sb[0].blk);
          sb.pop_front();
        end
        tags.push_back(bus.out_tag);
        chk("blocks_done", 64'(bus.blocks_done), 64'(16'(done_cnt + 1)));
        done_cnt <= done_cnt + 1;
      end
    end
  end

  initial begin
    rst = 1'b1;
    man_done = 1'b0;
    eng_hang = 1'b0;
    eng_lat = 66;
    terr_prev = 1'b0;
    terr_cyc = 0;
    bus.zz_block_ready = 1'b1;
    bus.enable = 1'b1;
    bus.req0_block = {1024{1'b0}};
    bus.req1_block = {1024{1'b0}};
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;

    // Reset values, readies held low under reset even with requests pending
    tick(3);
    chk("rst_ready0", 64'(bus.req0_ready), 64'd0);
    chk("rst_ready1", 64'(bus.req1_ready), 64'd0);
    chk("rst_zz_start", 64'(bus.zz_start), 64'd0);
    chk("rst_bvalid", 64'(bus.zz_block_valid), 64'd0);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_tag", 64'(bus.out_tag), 64'd0);
    chk("rst_timeout", 64'(bus.timeout_err), 64'd0);
    chk("rst_blocks", 64'(bus.blocks_done), 64'd0);
    chk_blk("rst_zz_block", bus.zz_block, {1024{1'b0}});
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    rst = 1'b0;
    grants.delete(); tags.delete(); xfer_cyc.delete();
    tick(2);

    // Single luma request, word k = k; enable dropped while in flight
    for (int i = 0; i < 64; i++) blk0[i*16 +: 16] = 16'(i);
    bus.req0_block = blk0;
    bus.req0_valid = 1'b1;
    wait_grants(1, 20, "t1_grant");
    bus.req0_valid = 1'b0;
    bus.enable = 1'b0;
    wait_done(1, 120, "t1_done");
    chk("t1_ov_pulse", 64'(bus.out_valid), 64'd0);
    chk("t1_ngrants", 64'(grants.size()), 64'd1);
    chk("t1_grant0", 64'(grants[0]), 64'd0);
    chk("t1_tag0", 64'(tags[0]), 64'd0);
    chk("t1_blocks", 64'(bus.blocks_done), 64'd1);
    bus.req1_valid = 1'b1;
    tick(5);
    chk("en_blocks_grant", 64'(grants.size()), 64'd1);
    bus.req1_valid = 1'b0;
    bus.enable = 1'b1;

    // Tie after reset alternates starting with requester 0
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    grants.delete(); tags.delete(); xfer_cyc.delete();
    eng_lat = 5;
    blk0 = rand_blk();
    blk1 = rand_blk();
    bus.req0_block = blk0;
    bus.req1_block = blk1;
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    wait_grants(4, 100, "t2_grants");
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    wait_done(4, 100, "t2_done");
    for (int i = 0; i < 4; i++) begin
      chk("t2_grant_seq", 64'(grants[i]), 64'(tie_seq[i]));
      chk("t2_tag_seq", 64'(tags[i]), 64'(tie_seq[i]));
    end
    chk("t2_blocks", 64'(bus.blocks_done), 64'd4);

    // Chroma streaming alone: back-to-back grants, one IDLE cycle apart
    grants.delete(); tags.delete(); xfer_cyc.delete();
    eng_lat = 3;
    bus.req1_block = rand_blk();
    bus.req1_valid = 1'b1;
    wait_grants(4, 100, "t3_grants");
    bus.req1_valid = 1'b0;
    wait_done(8, 100, "t3_done");
    for (int i = 0; i < 4; i++) begin
      chk("t3_grant", 64'(grants[i]), 64'd1);
      chk("t3_tag", 64'(tags[i]), 64'd1);
    end
    for (int i = 0; i < 3; i++) chk("t3_period", 64'(xfer_cyc[i+1] - xfer_cyc[i]), 64'(eng_lat + 2));
    chk("t3_blocks", 64'(bus.blocks_done), 64'd8);

    // Hung engine: abort after TIMEOUT wait cycles, no completion, sticky error
    grants.delete(); tags.delete();
    eng_hang = 1'b1;
    bus.req0_block = rand_blk();
    bus.req0_valid = 1'b1;
    wait_grants(1, 20, "t4_grant");
    bus.req0_valid = 1'b0;
    k = 0;
    while (bus.timeout_err !== 1'b1 && k < 300) begin
      @(negedge clk);
      k++;
    end
    tick(1);
    chk("t4_terr", 64'(bus.timeout_err), 64'd1);
    chk("t4_terr_time", 64'(terr_cyc), 64'(start_cyc + TO + 1));
    chk("t4_no_done", 64'(done_cnt), 64'd8);
    chk("t4_blocks", 64'(bus.blocks_done), 64'd8);
    if (sb.size() != 0) sb.pop_front();
    eng_hang = 1'b0;
    bus.req0_block = rand_blk();
    bus.req1_block = rand_blk();
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    wait_grants(2, 20, "t4_regrant");
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    chk("t4_rr_after_abort", 64'(grants[1]), 64'd1);
    wait_done(9, 50, "t4_done");
    chk("t4_terr_sticky", 64'(bus.timeout_err), 64'd1);

    // Reset ten cycles into WAIT_DONE, then a stray done
    grants.delete(); tags.delete();
    eng_hang = 1'b1;
    eng_lat = 66;
    bus.req1_valid = 1'b1;
    wait_grants(1, 20, "t5_grant");
    bus.req1_valid = 1'b0;
    tick(11);
    rst = 1'b1;
    tick(1);
    chk("t5_zz_start", 64'(bus.zz_start), 64'd0);
    chk("t5_bvalid", 64'(bus.zz_block_valid), 64'd0);
    chk("t5_out_valid", 64'(bus.out_valid), 64'd0);
    chk("t5_out_tag", 64'(bus.out_tag), 64'd0);
    chk("t5_timeout", 64'(bus.timeout_err), 64'd0);
    chk("t5_blocks", 64'(bus.blocks_done), 64'd0);
    chk_blk("t5_zz_block", bus.zz_block, {1024{1'b0}});
    tick(1);
    rst = 1'b0;
    man_done = 1'b1;
    tick(1);
    man_done = 1'b0;
    tick(3);
    chk("t5_stray_done", 64'(done_cnt), 64'd0);
    chk("t5_blocks_after", 64'(bus.blocks_done), 64'd0);
    grants.delete();
    eng_hang = 1'b0;
    eng_lat = 5;
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    wait_grants(1, 20, "t5_tie");
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    chk("t5_first_tie", 64'(grants[0]), 64'd0);
    wait_done(1, 50, "t5_done");
    chk("t5_blocks_one", 64'(bus.blocks_done), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
